// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module : vend_pkg
// Brief  : Shared types and constants for the cola vending transaction block.
// Rev    : 1.0  initial release
// ============================================================================
package vend_pkg;

    // One-hot transaction states
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        COLLECT = 4'b0010,
        VEND    = 4'b0100,
        RETURN  = 4'b1000
    } state_t;

    // Coin values in half-yuan units
    localparam int HALF_VAL = 1;
    localparam int ONE_VAL  = 2;

    // Default product price in half-yuan units (2.0 yuan)
    localparam int DEFAULT_PRICE = 4;

endpackage
`default_nettype wire

// File: rtl/vend_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module : vend_timeout_cnt
// Brief  : Inactivity counter for the COLLECT state; pulses expired on the
//          cycle whose edge completes TIMEOUT idle cycles.
// Rev    : 1.0  initial release
// ============================================================================
module vend_timeout_cnt #(
    parameter int TIMEOUT = 1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // The edge taken while cnt holds TIMEOUT-1 is the TIMEOUT-th idle edge
    assign expired = en && !clr && (cnt == LAST);

    // Count idle cycles; any clear (coin or leaving COLLECT) restarts from zero
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vend_dispense_ctrl
// Brief  : Vending transaction controller: coin credit, dispenser handshake,
//          stock tracking and paced half-yuan change/refund ejection.
// Rev    : 1.0  initial release
// ============================================================================
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                coin_half,
    input  logic                coin_one,
    input  logic                cancel,
    input  logic                restock,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic                chg_pulse,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out,
    output logic                busy
);

    state_t              state;
    logic [1:0]          coin_val;
    logic                coin_seen;
    logic                coin_window;
    logic                coin_ok;
    logic [CREDIT_W:0]   credit_sum;
    logic                price_hit;
    logic [CREDIT_W-1:0] credit_left;
    logic                timeout_clr;
    logic                timeout_en;
    logic                timeout_hit;

    // Coin value and acceptance decode; the extra sum bit flags credit overflow
    assign coin_val    = (coin_half ? 2'(HALF_VAL) : 2'd0) + (coin_one ? 2'(ONE_VAL) : 2'd0);
    assign coin_seen   = (coin_val != 2'd0);
    assign coin_window = (state == IDLE) || (state == COLLECT);
    assign credit_sum  = {1'b0, credit} + (CREDIT_W + 1)'(coin_val);
    assign coin_ok     = coin_window && coin_seen && (stock != '0) && !credit_sum[CREDIT_W];
    assign price_hit   = (credit_sum >= (CREDIT_W + 1)'(PRICE));
    assign credit_left = credit_sum[CREDIT_W-1:0] - CREDIT_W'(PRICE);

    // Status decodes straight from registers
    assign sold_out = (stock == '0);
    assign busy     = (state == VEND) || (state == RETURN);

    // Inactivity timer runs only while collecting with no accepted coin
    assign timeout_en  = (state == COLLECT);
    assign timeout_clr = coin_ok || (state != COLLECT);

    vend_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (timeout_clr),
        .en        (timeout_en),
        .expired   (timeout_hit)
    );

    // Transaction FSM with credit, stock and registered actuator outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            credit    <= '0;
            stock     <= STOCK_W'(STOCK_INIT);
            disp_req  <= 1'b0;
            chg_pulse <= 1'b0;
            coin_rej  <= 1'b0;
        end else begin
            coin_rej <= coin_seen && !coin_ok;
            unique case (state)
                IDLE: begin
                    if (restock) begin
                        stock <= STOCK_W'(STOCK_INIT);
                    end
                    if (coin_ok) begin
                        if (price_hit) begin
                            credit   <= credit_left;
                            disp_req <= 1'b1;
                            state    <= VEND;
                        end else begin
                            credit <= credit_sum[CREDIT_W-1:0];
                            state  <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        // A coin in the cancel cycle is banked and refunded
                        if (coin_ok) begin
                            credit <= credit_sum[CREDIT_W-1:0];
                        end
                        chg_pulse <= 1'b1;
                        state     <= RETURN;
                    end else if (coin_ok) begin
                        if (price_hit) begin
                            credit   <= credit_left;
                            disp_req <= 1'b1;
                            state    <= VEND;
                        end else begin
                            credit <= credit_sum[CREDIT_W-1:0];
                        end
                    end else if (timeout_hit) begin
                        chg_pulse <= 1'b1;
                        state     <= RETURN;
                    end
                end
                VEND: begin
                    if (disp_ack) begin
                        stock    <= stock - 1'b1;
                        disp_req <= 1'b0;
                        if (credit != '0) begin
                            chg_pulse <= 1'b1;
                            state     <= RETURN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RETURN: begin
                    // High cycle ejects a coin; low cycle decides whether to continue
                    if (chg_pulse) begin
                        credit    <= credit - 1'b1;
                        chg_pulse <= 1'b0;
                    end else if (credit == '0) begin
                        state <= IDLE;
                    end else begin
                        chg_pulse <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    disp_req  <= 1'b0;
                    chg_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/vend_dispense_ctrl.md
# vend_dispense_ctrl

Transaction controller for the cola vending machine. It accumulates coin credit in half-yuan units, sequences the dispenser through a req/ack handshake, and tracks stock. It also returns change, or refunds on cancel/timeout, as a paced train of half-yuan ejector pulses. It sits between the debounced coin/button inputs and the dispenser and coin-ejector actuators.

## Interface
Parameters:
- PRICE, 4, product price in half-yuan units (4 = 2.0 yuan)
- CREDIT_W, 4, credit register width
- STOCK_W, 4, stock counter width
- STOCK_INIT, 8, stock value after reset or restock
- TIMEOUT, 1000, idle cycles in COLLECT before auto-refund

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- coin_half  in  1  single-cycle pulse, 0.5 yuan inserted
- coin_one  in  1  single-cycle pulse, 1.0 yuan inserted
- cancel  in  1  single-cycle pulse, user requests refund
- restock  in  1  single-cycle pulse, reload stock
- disp_ack  in  1  dispenser accepted the vend
- disp_req  out  1  vend request, held until ack
- chg_pulse  out  1  eject one half-yuan coin
- coin_rej  out  1  pulse, inserted coin not accepted (routed to return chute)
- credit  out  CREDIT_W  current credit, half-yuan units
- stock  out  STOCK_W  remaining products
- sold_out  out  1  stock == 0
- busy  out  1  state is VEND or RETURN

## Operation
- One-hot FSM with states IDLE, COLLECT, VEND, RETURN. Coin value is v = coin_half + 2*coin_one; both pulses in one cycle gives v = 3.
- **Coin acceptance** (IDLE/COLLECT only):
  - A coin is rejected with a coin_rej pulse on the next cycle if stock == 0, or if credit + v > 2^CREDIT_W − 1.
  - A rejected coin leaves credit unchanged.
  - All coins arriving in VEND or RETURN are rejected.
- **IDLE**:
  - Accepted coin with credit + v < PRICE: credit += v, go to COLLECT.
  - Accepted coin with credit + v ≥ PRICE: credit = credit + v − PRICE, go to VEND.
  - cancel is ignored.
  - restock sets stock = STOCK_INIT. restock is ignored in all other states.
- **COLLECT**:
  - Same coin rules as IDLE.
  - cancel goes to RETURN. If a coin arrives in the same cycle, the coin is accepted first and included in the refund.
  - The timeout counter clears on every accepted coin. It increments each COLLECT cycle otherwise; reaching TIMEOUT goes to RETURN.
- **VEND**:
  - disp_req = 1 throughout the state.
  - On a cycle with disp_ack = 1: stock −= 1, then go to RETURN if credit > 0, else to IDLE.
  - cancel is ignored. disp_ack outside VEND is ignored.
- **RETURN**:
  - chg_pulse alternates 1, 0, 1, 0, …, starting high on the first RETURN cycle.
  - Credit decrements on each high cycle. The FSM leaves for IDLE on the low cycle that follows the pulse bringing credit to 0.
- **Derived outputs**: sold_out = (stock == 0), combinational from the register. Stock never decrements below 0, because VEND is unreachable at stock 0.

## Timing
- Reset values:
  - State IDLE; credit 0; stock STOCK_INIT; timeout counter 0.
  - disp_req, chg_pulse, coin_rej all 0; busy 0; sold_out 0 (when STOCK_INIT > 0).
- Reset mid-transaction discards credit and any pending vend with no refund. This is accepted behaviour.
- All outputs are registered except sold_out and busy, which decode registers.
- **Coin sampled at edge k**:
  - credit updates at k.
  - If the price is reached, disp_req is high from k, i.e. visible in cycle k+1.
- **disp_ack high in the cycle before edge m**: disp_req is low after m, and stock has decremented at m.
- Refund of N half-units takes exactly 2N cycles in RETURN.
- COLLECT→RETURN on timeout occurs TIMEOUT cycles after the last accepted coin.

## Structure
- Package vend_pkg holds:
  - the state type with one-hot encoding;
  - HALF_VAL = 1 and ONE_VAL = 2;
  - the default PRICE.
- Sub-module vend_timeout_cnt holds the COLLECT inactivity counter. Its inputs are clear/enable and its output is an expired pulse. Its width is derived from TIMEOUT with $clog2.
- The FSM, credit datapath, and stock counter live in the top module.

## Test plan
- **Exact price**: coin_one, coin_one → disp_req rises one cycle after the second coin, credit = 0. Ack → stock 8→7, return to IDLE, no chg_pulse.
- **Overpay with change**: half, one, one (5 halves) → VEND with credit = 1. Ack → exactly one chg_pulse, then IDLE with credit 0.
- **Cancel**: one, half, then cancel → 3 chg_pulses on alternate cycles (6 cycles of RETURN), then IDLE.
- **Timeout**: single coin_half, then no input for TIMEOUT cycles (use a reduced TIMEOUT) → RETURN, then one chg_pulse.
- **Sold out**: set stock to 1 and complete a vend → sold_out = 1. Next coin_one → coin_rej pulse, credit stays 0. restock → stock 8, sold_out 0.
- **Boundary cases**:
  - coin during VEND → coin_rej and credit unchanged.
  - cancel and coin_one in the same COLLECT cycle → refund includes the coin.
  - Reset asserted while disp_req is high → all outputs return to reset values asynchronously.
